cic_integrator_chain: RTL and testbench

- Parametrised successor to the single-stage CIC integrator: NSTAGE cascaded integrators with a built-in decimation strobe, for the decimating CIC front end.
- Runs entirely in one clock domain. Input samples are qualified by in_valid, and out_valid replaces the separate divided clock.
- Per-ratio effective-width wrap, optional saturation, and per-stage sticky overflow flags replace the old 2-bit toggle flag.
- Feeds the comb section, which consumes data_out on out_valid.

---
 rtl/cic_pkg.sv | 45 ++++
 rtl/cic_integrator_stage.sv | 65 ++++++
 rtl/cic_integrator_chain.sv | 112 +++++++++++
 tb/tb_cic_integrator_chain.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared constants and width/fit helpers for the CIC integrator and comb sections.
// The fit helpers work on a 64-bit signed word; ODW+1 must stay within it.
package cic_pkg;

  localparam int unsigned IDW_DEF       = 16;
  localparam int unsigned NSTAGE_DEF    = 3;
  localparam int unsigned MAX_LOG2R_DEF = 6;

  localparam logic [2:0] OS_BYPASS = 3'd0;
  localparam logic [2:0] OS_MAX    = 3'(MAX_LOG2R_DEF);

  localparam int unsigned FW = 64;
  typedef logic signed [FW-1:0] wide_t;

  function automatic int unsigned ew_of(input logic [2:0] os_sel, input int unsigned idw,
                                        input int unsigned nstage);
    return idw + nstage * 32'(os_sel);
  endfunction

  function automatic wide_t ew_hi(input int unsigned ew);
    return (wide_t'(1) <<< (ew - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t ew_lo(input int unsigned ew);
    return -(wide_t'(1) <<< (ew - 1));
  endfunction

  // Keep the low ew bits and sign-extend them back to the full word.
  function automatic wide_t fit_wrap(input wide_t x, input int unsigned ew);
    int unsigned sh;
    sh = FW - ew;
    return (x <<< sh) >>> sh;
  endfunction

  function automatic wide_t fit_sat(input wide_t x, input int unsigned ew);
    if (x > ew_hi(ew)) return ew_hi(ew);
    if (x < ew_lo(ew)) return ew_lo(ew);
    return x;
  endfunction

  function automatic logic fit_ovf(input wide_t x, input int unsigned ew);
    return (x > ew_hi(ew)) || (x < ew_lo(ew));
  endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// One integrator: accumulator kept at the effective width, wrap or saturate, sticky overflow.
module cic_integrator_stage
  import cic_pkg::*;
#(
  parameter int unsigned ODW = 34
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clear_i,
  input  logic           en_i,
  input  logic           sat_en_i,
  input  logic [7:0]     ew_i,
  input  logic [ODW-1:0] src_i,
  input  logic           ovf_clr_i,
  output logic [ODW-1:0] acc_o,
  output logic           ovf_hit_o,
  output logic           ovf_o
);

  logic [ODW-1:0]   acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic signed [ODW:0] sum;
  wide_t            sum_w, fit_w;
  int unsigned      ew;
  logic             unused_fit;

  always_comb begin
    ew        = 32'(ew_i);
    sum       = $signed({acc_q[ODW-1], acc_q}) + $signed({src_i[ODW-1], src_i});
    sum_w     = wide_t'(sum);
    fit_w     = sat_en_i ? fit_sat(sum_w, ew) : fit_wrap(sum_w, ew);
    ovf_hit_o = en_i && fit_ovf(sum_w, ew);

    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = fit_w[ODW-1:0];
    end

    // A fresh overflow beats a simultaneous clear.
    ovf_d = ovf_q;
    if (ovf_hit_o) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
  end

  assign unused_fit = ^fit_w[FW-1:ODW];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/cic_integrator_chain.sv
// NSTAGE cascaded CIC integrators with valid pipeline, decimation strobe, bypass and
// flush on a change of decimation ratio.
module cic_integrator_chain
  import cic_pkg::*;
#(
  parameter int unsigned IDW       = IDW_DEF,
  parameter int unsigned NSTAGE    = NSTAGE_DEF,
  parameter int unsigned MAX_LOG2R = MAX_LOG2R_DEF,
  parameter int unsigned ODW       = IDW + NSTAGE * MAX_LOG2R
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        os_sel,
  input  logic              sat_en,
  input  logic              in_valid,
  input  logic [IDW-1:0]    data_in,
  input  logic              ovf_clr,
  output logic              out_valid,
  output logic [ODW-1:0]    data_out,
  output logic [NSTAGE-1:0] stage_ovf,
  output logic              ovf_flag
);

  logic [2:0]           os_q;
  logic [NSTAGE:1]      v_q, v_d;
  logic [NSTAGE:0]      v;
  logic [MAX_LOG2R-1:0] cnt_q, cnt_d, cnt_last;
  logic                 out_valid_q, out_valid_d;
  logic [ODW-1:0]       data_out_q, data_out_d;
  logic                 ovf_flag_q, ovf_flag_d;

  logic                 bypass, flush, clear, fire;
  logic [7:0]           ew;
  logic [ODW-1:0]       data_sext;
  logic [ODW-1:0]       acc [NSTAGE+1];
  logic [NSTAGE-1:0]    ovf_hit;

  assign bypass    = (os_sel == OS_BYPASS) || (32'(os_sel) > MAX_LOG2R);
  assign flush     = (os_sel != os_q);
  assign clear     = flush | bypass;
  assign ew        = 8'(ew_of(os_sel, IDW, NSTAGE));
  assign cnt_last  = MAX_LOG2R'((32'd1 << os_sel) - 32'd1);
  assign data_sext = {{(ODW-IDW){data_in[IDW-1]}}, data_in};
  assign v         = {v_q, in_valid};
  assign acc[0]    = data_sext;

  for (genvar k = 1; k <= NSTAGE; k++) begin : g_stage
    cic_integrator_stage #(
      .ODW(ODW)
    ) u_stage (
      .clk_i     (clk),
      .rst_i     (reset),
      .clear_i   (clear),
      .en_i      (v[k-1] & ~clear),
      .sat_en_i  (sat_en),
      .ew_i      (ew),
      .src_i     (acc[k-1]),
      .ovf_clr_i (ovf_clr),
      .acc_o     (acc[k]),
      .ovf_hit_o (ovf_hit[k-1]),
      .ovf_o     (stage_ovf[k-1])
    );
  end

  always_comb begin
    v_d  = clear ? '0 : v[NSTAGE-1:0];
    fire = ~clear & v[NSTAGE] & (cnt_q == cnt_last);

    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (v[NSTAGE]) begin
      cnt_d = (cnt_q == cnt_last) ? '0 : cnt_q + MAX_LOG2R'(1);
    end

    out_valid_d = 1'b0;
    data_out_d  = data_out_q;
    if (bypass) begin
      out_valid_d = in_valid;
      if (in_valid) data_out_d = data_sext;
    end else if (fire) begin
      out_valid_d = 1'b1;
      data_out_d  = acc[NSTAGE];
    end

    // On a clear only overflows landing this cycle keep the summary flag set.
    ovf_flag_d = ovf_clr ? |ovf_hit : |stage_ovf;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      os_q        <= '0;
      v_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      ovf_flag_q  <= 1'b0;
    end else begin
      os_q        <= os_sel;
      v_q         <= v_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      ovf_flag_q  <= ovf_flag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign ovf_flag  = ovf_flag_q;

endmodule

// File: tb/tb_cic_integrator_chain.sv
// Self-checking bench for cic_integrator_chain: sample-level model feeds a scoreboard queue.
module tb_cic_integrator_chain;

  localparam int unsigned IDW       = 16;
  localparam int unsigned NSTAGE    = 3;
  localparam int unsigned MAX_LOG2R = 6;
  localparam int unsigned ODW       = IDW + NSTAGE * MAX_LOG2R;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        os_sel;
  logic              sat_en;
  logic              in_valid;
  logic [IDW-1:0]    data_in;
  logic              ovf_clr;
  logic              out_valid;
  logic [ODW-1:0]    data_out;
  logic [NSTAGE-1:0] stage_ovf;
  logic              ovf_flag;

  cic_integrator_chain #(
    .IDW       (IDW),
    .NSTAGE    (NSTAGE),
    .MAX_LOG2R (MAX_LOG2R),
    .ODW       (ODW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .os_sel    (os_sel),
    .sat_en    (sat_en),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .ovf_clr   (ovf_clr),
    .out_valid (out_valid),
    .data_out  (data_out),
    .stage_ovf (stage_ovf),
    .ovf_flag  (ovf_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ODW-1:0] data;
    int             cyc;
  } exp_t;

  exp_t              sb[$];
  int                cyc = 0;
  int                checks = 0;
  int                failures = 0;
  longint            macc[NSTAGE];
  int                mcnt;
  int                m_os;
  bit                m_sat;
  logic [NSTAGE-1:0] m_flags;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every out_valid must match the head entry in value and cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out_valid cyc=%0d data_out=%0h", cyc, data_out);
        end else begin
          e = sb.pop_front();
          if (data_out !== e.data || cyc != e.cyc) begin
            failures++;
            $display("FAIL out_sample got=%0h@%0d exp=%0h@%0d", data_out, cyc, e.data, e.cyc);
          end
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_out_valid exp=%0h@%0d now=%0d", e.data, e.cyc, cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic model_clear();
    for (int k = 0; k < NSTAGE; k++) macc[k] = 0;
    mcnt = 0;
  endtask

  task automatic model_sample(input logic signed [IDW-1:0] d);
    longint src, s, hi, lo, md, dl;
    int     ew;
    exp_t   e;
    dl = d;
    if (m_os == 0 || m_os > MAX_LOG2R) begin
      e.data = dl[ODW-1:0];
      e.cyc  = cyc + 1;
      sb.push_back(e);
      return;
    end
    ew  = IDW + NSTAGE * m_os;
    hi  = (longint'(1) << (ew - 1)) - 1;
    lo  = -hi - 1;
    md  = longint'(1) << ew;
    src = dl;
    for (int k = 0; k < NSTAGE; k++) begin
      s = macc[k] + src;
      if (s > hi || s < lo) m_flags[k] = 1'b1;
      if (m_sat) begin
        if (s > hi) s = hi;
        if (s < lo) s = lo;
      end else begin
        s = s & (md - 1);
        if (s > hi) s = s - md;
      end
      macc[k] = s;
      src     = s;
    end
    mcnt++;
    if (mcnt == (1 << m_os)) begin
      mcnt   = 0;
      s      = macc[NSTAGE-1];
      e.data = s[ODW-1:0];
      e.cyc  = cyc + NSTAGE + 1;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic signed [IDW-1:0] d);
    in_valid = 1'b1;
    data_in  = d;
    model_sample(d);
    idle(1);
    in_valid = 1'b0;
  endtask

  task automatic set_os(input int v);
    os_sel = 3'(v);
    m_os   = v;
    model_clear();
    idle(1);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    ovf_clr  = 1'b0;
    sb.delete();
    model_clear();
    m_flags = '0;
    idle(2);
    reset = 1'b0;
    idle(2);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) idle(1);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    logic [ODW-1:0] zero_w;
    zero_w = '0;
    checks++;
    if ({out_valid, data_out, stage_ovf, ovf_flag} !== {1'b0, zero_w, {NSTAGE{1'b0}}, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got=%0b/%0h/%0b/%0b exp=0", out_valid, data_out, stage_ovf,
               ovf_flag);
    end
    send(16'sd3); send(16'sd5); send(16'sd7); send(16'sd9);
    wait_drain();
    send(16'sd1); send(16'sd1);
    // Assert reset asynchronously mid-stream with a sample on the bus.
    in_valid = 1'b1;
    data_in  = 16'd7;
    reset    = 1'b1;
    #1;
    checks++;
    if (data_out !== zero_w) begin
      failures++;
      $display("FAIL reset_async_data got=%0h exp=0", data_out);
    end
    checks++;
    if (out_valid !== 1'b0 || stage_ovf !== '0 || ovf_flag !== 1'b0) begin
      failures++;
      $display("FAIL reset_async_ctrl got=%0b/%0b/%0b exp=0", out_valid, stage_ovf, ovf_flag);
    end
    sb.delete();
    model_clear();
    in_valid = 1'b0;
    idle(2);
    checks++;
    if (data_out !== zero_w || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold got=%0h/%0b exp=0", data_out, out_valid);
    end
    reset = 1'b0;
    idle(2);
    for (int i = 0; i < 4; i++) send(16'sd1);
    wait_drain();
    checks++;
    if (data_out !== ODW'(20)) begin
      failures++;
      $display("FAIL reset_first_group got=%0d exp=20", data_out);
    end
  endtask

  task automatic test_ratio2_ramp();
    set_os(1);
    for (int i = 0; i < 6; i++) send(16'sd1);
    wait_drain();
    checks++;
    if (data_out !== ODW'(56)) begin
      failures++;
      $display("FAIL ramp_last got=%0d exp=56", data_out);
    end
  endtask

  task automatic test_wrap();
    int seen_at;
    seen_at = -1;
    do_reset();
    sat_en = 1'b0;
    m_sat  = 1'b0;
    set_os(1);
    for (int i = 0; i < 6; i++) begin
      send(16'sh7FFF);
      if (seen_at < 0 && stage_ovf != '0) begin
        seen_at = i;
        checks++;
        if (stage_ovf[NSTAGE-1] !== 1'b1) begin
          failures++;
          $display("FAIL wrap_stage_ovf got=%0b exp=1xx", stage_ovf);
        end
        checks++;
        if (ovf_flag !== 1'b0) begin
          failures++;
          $display("FAIL wrap_flag_lag got=%0b exp=0", ovf_flag);
        end
      end else if (seen_at >= 0 && seen_at == i - 1) begin
        checks++;
        if (ovf_flag !== 1'b1) begin
          failures++;
          $display("FAIL wrap_flag_set got=%0b exp=1", ovf_flag);
        end
      end
    end
    if (seen_at < 0) begin
      checks++;
      failures++;
      $display("FAIL wrap_no_overflow got=%0b exp=nonzero", stage_ovf);
    end
    wait_drain();
    checks++;
    if (stage_ovf !== m_flags || ovf_flag !== 1'b1) begin
      failures++;
      $display("FAIL wrap_flags got=%0b/%0b exp=%0b/1", stage_ovf, ovf_flag, m_flags);
    end
  endtask

  task automatic test_saturate();
    longint neg;
    neg = -262144;
    do_reset();
    sat_en = 1'b1;
    m_sat  = 1'b1;
    set_os(1);
    for (int i = 0; i < 10; i++) send(16'sh7FFF);
    wait_drain();
    checks++;
    if (data_out !== ODW'(262143)) begin
      failures++;
      $display("FAIL sat_pos got=%0d exp=262143", data_out);
    end
    for (int i = 0; i < 40; i++) send(16'sh8000);
    wait_drain();
    checks++;
    if (data_out !== neg[ODW-1:0]) begin
      failures++;
      $display("FAIL sat_neg got=%0h exp=%0h", data_out, neg[ODW-1:0]);
    end
    sat_en = 1'b0;
    m_sat  = 1'b0;
  endtask

  task automatic test_flag_clear();
    bit done;
    checks++;
    if (stage_ovf !== m_flags) begin
      failures++;
      $display("FAIL flags_before_clear got=%0b exp=%0b", stage_ovf, m_flags);
    end
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    m_flags = '0;
    checks++;
    if (stage_ovf !== '0 || ovf_flag !== 1'b0) begin
      failures++;
      $display("FAIL flag_clear got=%0b/%0b exp=0/0", stage_ovf, ovf_flag);
    end
    do_reset();
    ovf_clr = 1'b1;
    done    = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      send(16'sh7FFF);
      if (stage_ovf != '0) begin
        done = 1'b1;
        checks++;
        if (stage_ovf[NSTAGE-1] !== 1'b1 || ovf_flag !== 1'b1) begin
          failures++;
          $display("FAIL clr_vs_set got=%0b/%0b exp=1xx/1", stage_ovf, ovf_flag);
        end
      end
    end
    ovf_clr = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL clr_vs_set_no_overflow got=%0b exp=nonzero", stage_ovf);
    end
    wait_drain();
  endtask

  task automatic test_ratio_change();
    do_reset();
    set_os(1);
    send(16'sd2); send(16'sd4); send(16'sd6);
    idle(6);
    set_os(2);
    for (int i = 0; i < 4; i++) send(16'sd1);
    wait_drain();
    checks++;
    if (data_out !== ODW'(20)) begin
      failures++;
      $display("FAIL ratio_change got=%0d exp=20", data_out);
    end
  endtask

  task automatic test_bypass();
    longint m5;
    m5 = -5;
    set_os(0);
    send(-16'sd5);
    checks++;
    if (out_valid !== 1'b1 || data_out !== m5[ODW-1:0]) begin
      failures++;
      $display("FAIL bypass_neg got=%0b/%0h exp=1/%0h", out_valid, data_out, m5[ODW-1:0]);
    end
    idle(1);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bypass_idle got=%0b exp=0", out_valid);
    end
    set_os(7);
    send(16'sd9);
    checks++;
    if (out_valid !== 1'b1 || data_out !== ODW'(9)) begin
      failures++;
      $display("FAIL bypass_os7 got=%0b/%0h exp=1/9", out_valid, data_out);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back_gaps();
    for (int r = 2; r <= 3; r++) begin
      set_os(r);
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 2) == 0) idle(1);
        else send(16'($urandom));
      end
      wait_drain();
    end
  endtask

  initial begin
    reset    = 1'b1;
    os_sel   = 3'd2;
    sat_en   = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;
    ovf_clr  = 1'b0;
    m_os     = 2;
    m_sat    = 1'b0;
    m_flags  = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    test_reset();
    test_ratio2_ramp();
    test_wrap();
    test_saturate();
    test_flag_clear();
    test_ratio_change();
    test_bypass();
    test_back_to_back_gaps();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
